joypad_serial_reader: RTL and testbench

Drives the serial protocol of the SNES-style debug joypad and turns it into twelve parallel button lines. Each line is active-low and feeds one debounce/edge-detect stage per button. The block polls the pad at a fixed rate: a latch pulse, then 16 clock pulses, sampling the serial data line. The parallel outputs update once per completed frame.

---
 rtl/joypad_pkg.sv | 36 +++
 rtl/joypad_bit_sync.sv | 30 +++
 rtl/joypad_serial_reader.sv | 164 ++++++++++++++++
 tb/tb_joypad_serial_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/joypad_pkg.sv
// Shared definitions for the SNES-style joypad serial reader.
//   - state_e             : frame sequencer states
//   - BTN_B .. BTN_R      : bit position of each button in the parallel output
//   - NUM_BUTTONS         : width of the parallel button bus (12)
//   - FRAME_BITS          : serial bits clocked out of the pad per frame (16)
//   - PRESENCE_LO/HI      : serial bits that a connected pad always reports released
package joypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_e;

  localparam int NUM_BUTTONS = 12;
  localparam int FRAME_BITS  = 16;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int PRESENCE_LO = 12;
  localparam int PRESENCE_HI = 15;

endpackage

// File: rtl/joypad_bit_sync.sv
// Two-flop synchronizer for the asynchronous joypad data line.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   async_i: asynchronous input
//   sync_o : synchronized output (reset value 1, i.e. "released")
module joypad_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/joypad_serial_reader.sv
// Polls an SNES-style joypad (latch pulse + 16 shift clocks) at a fixed rate
// and presents the twelve buttons as active-low parallel levels.
//   clock         : system clock
//   reset         : synchronous active-low reset
//   joyData       : serial data from pad (asynchronous, 0 = pressed)
//   joyLatch      : latch strobe to pad, active high
//   joyClock      : shift clock to pad, idles high
//   outButtons    : button levels, active low, order B,Y,Sel,Start,Up,Dn,L,R,A,X,L,R
//   outValid      : one-cycle pulse when outButtons has just been loaded
//   outPadPresent : last frame reported bits 12..15 released
// Optional feature: define JOYPAD_PRESENCE_CHECK_EN to force outButtons to
// all-released whenever the presence bits indicate no pad.
module joypad_serial_reader
  import joypad_pkg::*;
#(
  parameter int CLOCK_DIV     = 300,
  parameter int POLL_INTERVAL = 833333
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        joyData,
  output logic        joyLatch,
  output logic        joyClock,
  output logic [11:0] outButtons,
  output logic        outValid,
  output logic        outPadPresent
);

  localparam int                   PHASE_W     = $clog2(2 * CLOCK_DIV);
  localparam logic [PHASE_W-1:0]   HALF_LAST   = PHASE_W'(CLOCK_DIV - 1);
  localparam logic [PHASE_W-1:0]   LATCH_LAST  = PHASE_W'(2 * CLOCK_DIV - 1);
  localparam logic [31:0]          POLL_RELOAD = 32'(POLL_INTERVAL - 1);
  localparam logic [3:0]           LAST_BIT    = 4'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [31:0]             poll_q, poll_d;
  logic [3:0]              idx_q, idx_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    latch_q, latch_d;
  logic                    jclk_q, jclk_d;
  logic [NUM_BUTTONS-1:0]  buttons_q, buttons_d;
  logic                    valid_q, valid_d;
  logic                    present_q, present_d;

  logic data_sync;
  logic pad_ok;

  joypad_bit_sync u_sync (
    .clk    (clock),
    .rst_n  (reset),
    .async_i(joyData),
    .sync_o (data_sync)
  );

  assign pad_ok = &shift_q[PRESENCE_HI:PRESENCE_LO];

  // NOTE: every *_d gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    latch_d   = latch_q;
    jclk_d    = jclk_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    present_d = present_q;
    // Poll timer runs through the whole frame and saturates at zero.
    poll_d    = (poll_q != '0) ? poll_q - 32'd1 : '0;

    unique case (state_q)
      ST_IDLE: phase_d = '0;
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          phase_d = '0;
          latch_d = 1'b0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (phase_q == HALF_LAST) begin
          phase_d        = '0;
          shift_d[idx_q] = data_sync;
          jclk_d         = 1'b0;
          state_d        = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          jclk_d  = 1'b1;
          if (idx_q == LAST_BIT) begin
            // Outputs are loaded on entry to DONE so they are already
            // visible during the DONE cycle alongside the valid pulse.
            state_d   = ST_DONE;
            valid_d   = 1'b1;
            present_d = pad_ok;
`ifdef JOYPAD_PRESENCE_CHECK_EN
            buttons_d = pad_ok ? shift_q[NUM_BUTTONS-1:0] : '1;
`else
            buttons_d = shift_q[NUM_BUTTONS-1:0];
`endif
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_HIGH;
          end
        end
      end
      ST_DONE: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start from IDLE, or straight out of DONE when the poll interval
    // has already elapsed, so back-to-back frames have no gap.
    if ((state_q == ST_IDLE || state_q == ST_DONE) && poll_q == '0) begin
      poll_d  = POLL_RELOAD;
      idx_d   = '0;
      phase_d = '0;
      latch_d = 1'b1;
      jclk_d  = 1'b1;
      state_d = ST_LATCH;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      poll_q    <= '0;
      idx_q     <= '0;
      // NOTE: the shift register is reset to all-released, even though every
      // bit is rewritten each frame, so no X can reach outButtons.
      shift_q   <= '1;
      latch_q   <= 1'b0;
      jclk_q    <= 1'b1;
      buttons_q <= '1;
      valid_q   <= 1'b0;
      present_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      poll_q    <= poll_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      latch_q   <= latch_d;
      jclk_q    <= jclk_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      present_q <= present_d;
    end
  end

  assign joyLatch      = latch_q;
  assign joyClock      = jclk_q;
  assign outButtons    = buttons_q;
  assign outValid      = valid_q;
  assign outPadPresent = present_q;

endmodule

// File: tb/tb_joypad_serial_reader.sv
// Self-checking bench for joypad_serial_reader with CLOCK_DIV=4.
// Main instance polls every 200 cycles; a second instance polls every 100
// cycles (shorter than a frame) to cover back-to-back frames.
module tb_joypad_serial_reader;
  import joypad_pkg::*;

  logic        clock;
  logic        reset;
  logic        joy_data;
  logic        joy_latch;
  logic        joy_clk;
  logic [11:0] out_buttons;
  logic        out_valid;
  logic        out_present;

  logic        reset_f;
  logic        joy_data_f;
  logic        joy_latch_f;
  logic        joy_clk_f;
  logic [11:0] out_buttons_f;
  logic        out_valid_f;
  logic        out_present_f;

  joypad_serial_reader #(.CLOCK_DIV(4), .POLL_INTERVAL(200)) dut (
    .clock        (clock),
    .reset        (reset),
    .joyData      (joy_data),
    .joyLatch     (joy_latch),
    .joyClock     (joy_clk),
    .outButtons   (out_buttons),
    .outValid     (out_valid),
    .outPadPresent(out_present)
  );

  joypad_serial_reader #(.CLOCK_DIV(4), .POLL_INTERVAL(100)) dut_fast (
    .clock        (clock),
    .reset        (reset_f),
    .joyData      (joy_data_f),
    .joyLatch     (joy_latch_f),
    .joyClock     (joy_clk_f),
    .outButtons   (out_buttons_f),
    .outValid     (out_valid_f),
    .outPadPresent(out_present_f)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural pad: latch loads bit 0, each rising shift clock advances.
  logic [15:0] pattern;
  logic        force_low;
  int          pad_cnt = 16;

  always @(posedge joy_latch or posedge joy_clk) begin
    if (joy_latch) pad_cnt = 0;
    else           pad_cnt = pad_cnt + 1;
  end

  assign joy_data   = force_low ? 1'b0 :
                      (pad_cnt < 16) ? pattern[pad_cnt[3:0]] : 1'b1;
  assign joy_data_f = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame monitor results (cycles counted from the call).
  int m_first_latch, m_latch, m_low, m_pulses, m_valid, m_overlap, m_changed;

  task automatic run_frame(input int budget);
    logic        prev_clk;
    logic [11:0] prev_btn;
    prev_clk      = joy_clk;
    prev_btn      = out_buttons;
    m_first_latch = 0;
    m_latch       = 0;
    m_low         = 0;
    m_pulses      = 0;
    m_valid       = 0;
    m_overlap     = 0;
    m_changed     = 0;
    for (int c = 1; c <= budget; c++) begin
      step(1);
      if (joy_latch) begin
        m_latch++;
        if (m_first_latch == 0) m_first_latch = c;
      end
      if (!joy_clk) begin
        m_low++;
        if (prev_clk) m_pulses++;
      end
      if (joy_latch && !joy_clk) m_overlap++;
      if (out_buttons != prev_btn && !out_valid) m_changed++;
      prev_clk = joy_clk;
      prev_btn = out_buttons;
      if (out_valid) begin
        m_valid = c;
        break;
      end
    end
  endtask

  task automatic wait_latch(input int budget);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (joy_latch) break;
    end
    check("latch_seen", 32'(joy_latch), 32'd1);
  endtask

  logic [11:0] exp_low;
  int          k;

  initial begin
    reset     = 1'b0;
    reset_f   = 1'b0;
    pattern   = 16'hFFFF;
    force_low = 1'b0;
`ifdef JOYPAD_PRESENCE_CHECK_EN
    exp_low = 12'hFFF;
`else
    exp_low = 12'h000;
`endif

    // Reset state
    step(3);
    check("rst_latch",   32'(joy_latch),   32'd0);
    check("rst_clk",     32'(joy_clk),     32'd1);
    check("rst_buttons", 32'(out_buttons), 32'hFFF);
    check("rst_valid",   32'(out_valid),   32'd0);
    check("rst_present", 32'(out_present), 32'd0);

    // First frame, no buttons pressed
    @(negedge clock);
    reset = 1'b1;
    run_frame(300);
    check("f1_first_latch", 32'(m_first_latch), 32'd1);
    check("f1_latch_len",   32'(m_latch),       32'd8);
    check("f1_low_pulses",  32'(m_pulses),      32'd16);
    check("f1_low_cycles",  32'(m_low),         32'd64);
    check("f1_valid_cycle", 32'(m_valid),       32'd137);
    check("f1_overlap",     32'(m_overlap),     32'd0);
    check("f1_buttons",     32'(out_buttons),   32'hFFF);
    check("f1_present",     32'(out_present),   32'd1);

    // A pressed, presence bits high; next frame 200 cycles later
    pattern = 16'hFEFF;
    run_frame(300);
    check("a_valid_cycle", 32'(m_valid),            32'd200);
    check("a_buttons",     32'(out_buttons),        32'hEFF);
    check("a_bit",         32'(out_buttons[BTN_A]), 32'd0);
    check("a_present",     32'(out_present),        32'd1);
    check("a_no_glitch",   32'(m_changed),          32'd0);
    step(50);
    check("a_hold",        32'(out_buttons),        32'hEFF);
    check("a_valid_low",   32'(out_valid),          32'd0);

    // Data line stuck low
    force_low = 1'b1;
    run_frame(300);
    check("low_buttons", 32'(out_buttons), 32'(exp_low));
    check("low_present", 32'(out_present), 32'd0);

    // Pattern change during HIGH of bit 5
    force_low = 1'b0;
    pattern   = 16'hFFFF;
    wait_latch(300);
    step(48);
    check("b5_in_high", 32'(joy_clk), 32'd1);
    pattern[BTN_DOWN] = 1'b0;
    step(20);
    check("b5_mid_hold", 32'(out_buttons), 32'(exp_low));
    run_frame(200);
    check("b5_valid_cycle", 32'(m_valid),     32'd68);
    check("b5_buttons",     32'(out_buttons), 32'hFDF);
    check("b5_no_glitch",   32'(m_changed),   32'd0);

    // Reset during LOW of bit 9
    pattern = 16'hFDFF;
    wait_latch(300);
    step(85);
    check("b9_in_low", 32'(joy_clk), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step(1);
    check("mid_rst_latch",   32'(joy_latch),   32'd0);
    check("mid_rst_clk",     32'(joy_clk),     32'd1);
    check("mid_rst_buttons", 32'(out_buttons), 32'hFFF);
    check("mid_rst_valid",   32'(out_valid),   32'd0);
    check("mid_rst_present", 32'(out_present), 32'd0);
    step(3);
    check("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step(1);
    check("restart_latch", 32'(joy_latch), 32'd1);
    run_frame(300);
    check("restart_valid_cycle", 32'(m_valid),            32'd136);
    check("restart_buttons",     32'(out_buttons),        32'hDFF);
    check("restart_x_bit",       32'(out_buttons[BTN_X]), 32'd0);
    check("restart_present",     32'(out_present),        32'd1);

    // Poll interval shorter than a frame: back-to-back frames
    @(negedge clock);
    reset_f = 1'b1;
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      step(1);
      if (out_valid_f) begin
        k = c;
        break;
      end
    end
    check("fast_f1_valid", 32'(k), 32'd137);
    step(1);
    check("fast_f2_latch", 32'(joy_latch_f), 32'd1);
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      step(1);
      if (out_valid_f) begin
        k = c;
        break;
      end
    end
    check("fast_f2_valid", 32'(k), 32'd136);
    step(1);
    check("fast_f3_latch",   32'(joy_latch_f),   32'd1);
    check("fast_buttons",    32'(out_buttons_f), 32'hFFF);
    check("fast_present",    32'(out_present_f), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
